// File: rtl/mpu_lookup_sched_if.sv
// ---------------------------------------------------------------------------
// mpu_lookup_sched_if
// Bundle of every signal that crosses the boundary of the launch-lookup
// scheduler. Names are seen from the scheduler: I_* flow into it and O_* flow
// out of it.
//   slave  : scheduler side (reads I_*, drives O_*)
//   master : environment side (drives I_*, reads O_*)
// Signals:
//   I_Req/I_ThreadID           launch requests and their thread IDs
//   O_Grant                    one-hot grant pulse
//   O_Req_Lookup/O_ThreadID_Ld lookup request to the map manager
//   I_Ack_Lookup/I_Address/I_Length  map manager answer
//   I_Lane_Busy                per-lane busy flags
//   O_Dispatch/O_Disp_*        lane dispatch strobe and payload
//   O_Miss/O_Busy              miss pulse and scheduler-active flag
// ---------------------------------------------------------------------------
interface mpu_lookup_sched_if #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_LANE   = 4,
  parameter int WIDTH_ID   = 8,
  parameter int WIDTH_ADDR = 10
);
  logic [NUM_REQ-1:0]          I_Req;
  logic [NUM_REQ*WIDTH_ID-1:0] I_ThreadID;
  logic [NUM_REQ-1:0]          O_Grant;
  logic                        O_Req_Lookup;
  logic [WIDTH_ID-1:0]         O_ThreadID_Ld;
  logic                        I_Ack_Lookup;
  logic [WIDTH_ADDR-1:0]       I_Address;
  logic [WIDTH_ADDR-1:0]       I_Length;
  logic [NUM_LANE-1:0]         I_Lane_Busy;
  logic [NUM_LANE-1:0]         O_Dispatch;
  logic [WIDTH_ADDR-1:0]       O_Disp_Addr;
  logic [WIDTH_ADDR-1:0]       O_Disp_Len;
  logic [WIDTH_ID-1:0]         O_Disp_ID;
  logic                        O_Miss;
  logic                        O_Busy;

  modport slave (
    input  I_Req, I_ThreadID, I_Ack_Lookup, I_Address, I_Length, I_Lane_Busy,
    output O_Grant, O_Req_Lookup, O_ThreadID_Ld, O_Dispatch, O_Disp_Addr,
           O_Disp_Len, O_Disp_ID, O_Miss, O_Busy
  );

  modport master (
    output I_Req, I_ThreadID, I_Ack_Lookup, I_Address, I_Length, I_Lane_Busy,
    input  O_Grant, O_Req_Lookup, O_ThreadID_Ld, O_Dispatch, O_Disp_Addr,
           O_Disp_Len, O_Disp_ID, O_Miss, O_Busy
  );
endinterface

// File: rtl/mpu_lookup_sched.sv
// ---------------------------------------------------------------------------
// mpu_lookup_sched
// Schedules thread-launch lookups against the MPU instruction-memory map
// manager: round-robin arbitration of NUM_REQ requesters, one lookup
// handshake, then dispatch of the program to the lowest free lane.
// Ports:
//   clock  in  clock
//   reset  in  synchronous, active-high reset
//   bus    mpu_lookup_sched_if.slave (requests, lookup handshake, dispatch)
// Optional feature: define LOOKUP_TIMEOUT_EN to add an ack watchdog that
// abandons a lookup after TIMEOUT_CYC cycles in WAIT_ACK and reports a miss.
// Timing (all outputs registered):
//   cycle t   : O_Grant pulse (state LOOKUP)
//   cycle t+1 : O_Req_Lookup high (state WAIT_ACK)
//   ack seen  : next cycle O_Req_Lookup low, DISPATCH (or O_Miss if len 0)
//   DISPATCH  : next cycle after a free lane is seen, O_Dispatch pulse
// ---------------------------------------------------------------------------
module mpu_lookup_sched #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_LANE    = 4,
  parameter int WIDTH_ID    = 8,
  parameter int WIDTH_ADDR  = 10,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clock,
  input  logic                reset,
  mpu_lookup_sched_if.slave   bus
);

  localparam int WIDTH_PTR = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("mpu_lookup_sched: NUM_REQ must be >= 2");
  end
  if (NUM_LANE < 1) begin : g_bad_num_lane
    $error("mpu_lookup_sched: NUM_LANE must be >= 1");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mpu_lookup_sched: TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOOKUP   = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DISPATCH = 2'd3
  } state_t;

  state_t                  state_reg;
  logic [WIDTH_PTR-1:0]    ptr_reg;
  logic [WIDTH_ID-1:0]     id_reg;
  logic [WIDTH_ADDR-1:0]   addr_reg;
  logic [WIDTH_ADDR-1:0]   len_reg;
  logic [NUM_REQ-1:0]      grant_reg;
  logic                    req_lookup_reg;
  logic [NUM_LANE-1:0]     dispatch_reg;
  logic [WIDTH_ADDR-1:0]   disp_addr_reg;
  logic [WIDTH_ADDR-1:0]   disp_len_reg;
  logic [WIDTH_ID-1:0]     disp_id_reg;
  logic                    miss_reg;

`ifdef LOOKUP_TIMEOUT_EN
  localparam int WIDTH_TCNT = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WIDTH_TCNT-1:0] TCNT_LAST = WIDTH_TCNT'(TIMEOUT_CYC - 1);
  logic [WIDTH_TCNT-1:0]   tcnt_reg;
`endif

  // ------------------------------------------------------------------
  // Round-robin pick. Requesters above the pointer win first; if none of
  // them is requesting, the lowest requester overall wins (the wrap).
  // ------------------------------------------------------------------
  logic [NUM_REQ-1:0]   above_ptr;
  logic                 req_any;
  logic                 hi_any;
  logic [WIDTH_PTR-1:0] hi_idx;
  logic [WIDTH_PTR-1:0] lo_idx;
  logic [WIDTH_ID-1:0]  hi_id;
  logic [WIDTH_ID-1:0]  lo_id;
  logic [WIDTH_PTR-1:0] win_idx;
  logic [WIDTH_ID-1:0]  win_id;
  logic [NUM_REQ-1:0]   win_onehot;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_above
    assign above_ptr[gi] = (WIDTH_PTR'(gi) > ptr_reg);
  end

  assign req_any = |bus.I_Req;

  always_comb begin
    hi_any     = 1'b0;
    hi_idx     = '0;
    lo_idx     = '0;
    hi_id      = '0;
    lo_id      = '0;
    // Descending scan so the last assignment is the lowest matching index.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.I_Req[i]) begin
        lo_idx = WIDTH_PTR'(i);
        lo_id  = bus.I_ThreadID[i*WIDTH_ID +: WIDTH_ID];
      end
      if (bus.I_Req[i] && above_ptr[i]) begin
        hi_any = 1'b1;
        hi_idx = WIDTH_PTR'(i);
        hi_id  = bus.I_ThreadID[i*WIDTH_ID +: WIDTH_ID];
      end
    end
    win_idx = hi_any ? hi_idx : lo_idx;
    win_id  = hi_any ? hi_id  : lo_id;
    win_onehot = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // ------------------------------------------------------------------
  // Lowest free lane.
  // ------------------------------------------------------------------
  logic                lane_any;
  logic [NUM_LANE-1:0] lane_onehot;

  always_comb begin
    lane_any    = ~&bus.I_Lane_Busy;
    lane_onehot = '0;
    for (int j = NUM_LANE - 1; j >= 0; j--) begin
      if (!bus.I_Lane_Busy[j]) begin
        lane_onehot    = '0;
        lane_onehot[j] = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      ptr_reg        <= WIDTH_PTR'(NUM_REQ - 1);
      id_reg         <= '0;
      addr_reg       <= '0;
      len_reg        <= '0;
      grant_reg      <= '0;
      req_lookup_reg <= 1'b0;
      dispatch_reg   <= '0;
      disp_addr_reg  <= '0;
      disp_len_reg   <= '0;
      disp_id_reg    <= '0;
      miss_reg       <= 1'b0;
`ifdef LOOKUP_TIMEOUT_EN
      tcnt_reg       <= '0;
`endif
    end else begin
      // Single-cycle pulses default low.
      grant_reg    <= '0;
      dispatch_reg <= '0;
      miss_reg     <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (req_any) begin
            grant_reg <= win_onehot;
            id_reg    <= win_id;
            ptr_reg   <= win_idx;
            state_reg <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          req_lookup_reg <= 1'b1;
          state_reg      <= S_WAIT_ACK;
`ifdef LOOKUP_TIMEOUT_EN
          tcnt_reg       <= '0;
`endif
        end

        S_WAIT_ACK: begin
          if (bus.I_Ack_Lookup) begin
            req_lookup_reg <= 1'b0;
            addr_reg       <= bus.I_Address;
            len_reg        <= bus.I_Length;
            if (bus.I_Length == '0) begin
              miss_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              state_reg <= S_DISPATCH;
            end
          end
`ifdef LOOKUP_TIMEOUT_EN
          else if (tcnt_reg == TCNT_LAST) begin
            // Watchdog expiry: abandon the lookup and report it as a miss.
            req_lookup_reg <= 1'b0;
            miss_reg       <= 1'b1;
            state_reg      <= S_IDLE;
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
`endif
        end

        S_DISPATCH: begin
          if (lane_any) begin
            dispatch_reg  <= lane_onehot;
            disp_addr_reg <= addr_reg;
            disp_len_reg  <= len_reg;
            disp_id_reg   <= id_reg;
            state_reg     <= S_IDLE;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.O_Grant       = grant_reg;
  assign bus.O_Req_Lookup  = req_lookup_reg;
  assign bus.O_ThreadID_Ld = id_reg;
  assign bus.O_Dispatch    = dispatch_reg;
  assign bus.O_Disp_Addr   = disp_addr_reg;
  assign bus.O_Disp_Len    = disp_len_reg;
  assign bus.O_Disp_ID     = disp_id_reg;
  assign bus.O_Miss        = miss_reg;
  assign bus.O_Busy        = (state_reg != S_IDLE);

endmodule
